// File: rtl/esaxi_emesh_arbiter.sv
// esaxi_emesh_arbiter: merges the bridge's write and read-request emesh
// streams onto one registered emesh TX channel. Round-robin (or fixed
// write priority) arbitration, per-source wait back-pressure, and a read
// credit counter returned by read-response traffic.
//
// Handshake: every channel is valid/wait. A transfer happens in a cycle
// where X_access=1 and X_wait=0. A source holds access and packet stable
// while its wait is high. The TX register is reloaded when it is empty or
// when downstream is not stalling it (load = ~tx_access | ~tx_wait).
module esaxi_emesh_arbiter #(
  parameter int PW      = 104,
  parameter int MAX_RD  = 8,
  parameter bit WR_PRIO = 1'b0
) (
  input  logic          s_axi_aclk,
  input  logic          s_axi_aresetn,
  input  logic          wr_access,
  input  logic [PW-1:0] wr_packet,
  output logic          wr_wait,
  input  logic          rd_access,
  input  logic [PW-1:0] rd_packet,
  output logic          rd_wait,
  input  logic          rr_access,
  output logic          tx_access,
  output logic [PW-1:0] tx_packet,
  input  logic          tx_wait,
  output logic [7:0]    rd_outstanding,
  output logic          rr_underflow
);

  localparam logic [7:0] MAX_RD_C = 8'(MAX_RD);

  // Which source won the most recent actual transfer.
  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  grant_e          last_grant_q, last_grant_d;
  logic            tx_access_q,  tx_access_d;
  logic [PW-1:0]   tx_packet_q,  tx_packet_d;
  logic [7:0]      rd_cnt_q,     rd_cnt_d;
  logic            rr_uf_q,      rr_uf_d;

  logic load;
  logic wr_elig;
  logic rd_elig;
  logic grant_wr;
  logic grant_rd;
  logic wr_xfer;
  logic rd_xfer;

  // Eligibility, grant and per-source transfer strobes.
  always_comb begin
    load     = ~tx_access_q | ~tx_wait;
    wr_elig  = wr_access;
    // An rr_access this cycle does not free a credit until next cycle.
    rd_elig  = rd_access & (rd_cnt_q < MAX_RD_C);
    // Write wins when alone, under fixed priority, or when read had the
    // last turn; read wins whenever it is eligible and write does not.
    grant_wr = wr_elig & (~rd_elig | WR_PRIO | (last_grant_q == GRANT_RD));
    grant_rd = rd_elig & ~grant_wr;
    // Reset forces both waits high and blocks any transfer.
    wr_xfer  = s_axi_aresetn & load & grant_wr;
    rd_xfer  = s_axi_aresetn & load & grant_rd;
    wr_wait  = ~wr_xfer;
    rd_wait  = ~rd_xfer;
  end

  // Next-state: output register, round-robin pointer, credits, sticky error.
  always_comb begin
    tx_access_d  = tx_access_q;
    tx_packet_d  = tx_packet_q;
    last_grant_d = last_grant_q;
    rd_cnt_d     = rd_cnt_q;
    rr_uf_d      = rr_uf_q;

    if (load) begin
      if (wr_xfer) begin
        tx_access_d = 1'b1;
        tx_packet_d = wr_packet;
      end else if (rd_xfer) begin
        tx_access_d = 1'b1;
        tx_packet_d = rd_packet;
      end else begin
        // Packet content is left as-is; only the valid drops.
        tx_access_d = 1'b0;
      end
    end

    if (wr_xfer) begin
      last_grant_d = GRANT_WR;
    end else if (rd_xfer) begin
      last_grant_d = GRANT_RD;
    end

    if (rd_xfer && !rr_access) begin
      rd_cnt_d = rd_cnt_q + 8'd1;
    end else if (!rd_xfer && rr_access) begin
      if (rd_cnt_q != 8'd0) begin
        rd_cnt_d = rd_cnt_q - 8'd1;
      end else begin
        rr_uf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      tx_access_q  <= 1'b0;
      tx_packet_q  <= '0;
      last_grant_q <= GRANT_RD;
      rd_cnt_q     <= 8'd0;
      rr_uf_q      <= 1'b0;
    end else begin
      tx_access_q  <= tx_access_d;
      tx_packet_q  <= tx_packet_d;
      last_grant_q <= last_grant_d;
      rd_cnt_q     <= rd_cnt_d;
      rr_uf_q      <= rr_uf_d;
    end
  end

  assign tx_access      = tx_access_q;
  assign tx_packet      = tx_packet_q;
  assign rd_outstanding = rd_cnt_q;
  assign rr_underflow   = rr_uf_q;

endmodule

// File: tb/tb_esaxi_emesh_arbiter.sv
// Self-checking bench for esaxi_emesh_arbiter (round-robin, MAX_RD=3).
// A behavioural model tracks the TX register, read credits, sticky error
// and the last winner; a queue holds packets expected on the TX channel.
module tb_esaxi_emesh_arbiter;

  localparam int PW     = 104;
  localparam int MAX_RD = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          aresetn;
  logic          wr_access, rd_access, rr_access, tx_wait;
  logic [PW-1:0] wr_packet, rd_packet;
  logic          wr_wait, rd_wait, tx_access, rr_underflow;
  logic [PW-1:0] tx_packet;
  logic [7:0]    rd_outstanding;

  always #5 clk = ~clk;

  esaxi_emesh_arbiter #(.PW(PW), .MAX_RD(MAX_RD), .WR_PRIO(1'b0)) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (aresetn),
    .wr_access      (wr_access),
    .wr_packet      (wr_packet),
    .wr_wait        (wr_wait),
    .rd_access      (rd_access),
    .rd_packet      (rd_packet),
    .rd_wait        (rd_wait),
    .rr_access      (rr_access),
    .tx_access      (tx_access),
    .tx_packet      (tx_packet),
    .tx_wait        (tx_wait),
    .rd_outstanding (rd_outstanding),
    .rr_underflow   (rr_underflow)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [PW-1:0] exp_q[$];
  bit            m_txv;
  logic [PW-1:0] m_pkt;
  int            m_cnt;
  bit            m_uf;
  bit            m_last_wr;   // 0: read had the last turn (reset value)
  bit            p_load, p_wr_go, p_rd_go;

  function automatic logic [PW-1:0] rand_pkt();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[PW-1:0];
  endfunction

  // Decide who transfers this cycle from the current inputs and model state.
  function automatic void predict();
    bit we, re, pick_wr;
    p_load = !m_txv || !tx_wait;
    we = wr_access;
    re = rd_access && (m_cnt < MAX_RD);
    if (we && re) pick_wr = !m_last_wr;
    else          pick_wr = we;
    p_wr_go = aresetn && p_load && we && pick_wr;
    p_rd_go = aresetn && p_load && re && !pick_wr;
  endfunction

  // Apply the effect of the clock edge that just happened.
  task automatic commit();
    if (!aresetn) begin
      m_txv = 0; m_pkt = '0; m_cnt = 0; m_uf = 0; m_last_wr = 0;
      exp_q.delete();
    end else begin
      if (p_load) begin
        if (p_wr_go)      begin m_txv = 1; m_pkt = wr_packet; exp_q.push_back(wr_packet); end
        else if (p_rd_go) begin m_txv = 1; m_pkt = rd_packet; exp_q.push_back(rd_packet); end
        else              m_txv = 0;
      end
      if (p_wr_go) m_last_wr = 1;
      if (p_rd_go) m_last_wr = 0;
      if (p_rd_go && !rr_access) m_cnt = m_cnt + 1;
      else if (!p_rd_go && rr_access) begin
        if (m_cnt > 0) m_cnt = m_cnt - 1;
        else           m_uf = 1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    commit();
    #1;
  endtask

  // Sources present a new packet only after their current one transferred.
  task automatic new_pkts();
    if (p_wr_go) wr_packet = rand_pkt();
    if (p_rd_go) rd_packet = rand_pkt();
  endtask

  task automatic refresh_sources(int pct);
    if (p_wr_go || !wr_access) begin
      wr_access = ($urandom_range(99) < pct);
      wr_packet = rand_pkt();
    end
    if (p_rd_go || !rd_access) begin
      rd_access = ($urandom_range(99) < pct);
      rd_packet = rand_pkt();
    end
  endtask

  task automatic pulse_reset();
    aresetn = 0;
    predict();
    advance();
    aresetn = 1;
  endtask

  task automatic drain();
    wr_access = 0; rd_access = 0; tx_wait = 0;
    for (int i = 0; i < 300 && m_cnt > 0; i++) begin
      rr_access = 1; predict(); advance();
    end
    rr_access = 0; predict(); advance();
    predict(); @(negedge clk);
    checks++;
    if (rd_outstanding !== 8'(m_cnt)) begin errors++;
      $display("FAIL drain_count: got %0d expected %0d", rd_outstanding, m_cnt); end
    advance();
  endtask

  // ---------------- scoreboard on the TX channel ----------------
  always @(negedge clk) begin
    if (aresetn && tx_access && !tx_wait) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_order: unexpected packet %h, queue empty", tx_packet);
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (tx_packet !== e) begin errors++;
          $display("FAIL tx_order: got %h expected %h", tx_packet, e); end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    aresetn = 0; wr_access = 1; rd_access = 1; rr_access = 1; tx_wait = 0;
    wr_packet = rand_pkt(); rd_packet = rand_pkt();
    for (int i = 0; i < 2; i++) begin
      predict(); @(negedge clk);
      checks++;
      if (wr_wait !== 1'b1 || rd_wait !== 1'b1) begin errors++;
        $display("FAIL reset_waits: got wr=%b rd=%b expected 1 1", wr_wait, rd_wait); end
      advance();
    end
    aresetn = 1; wr_access = 0; rd_access = 0; rr_access = 0;
    predict(); @(negedge clk);
    checks++;
    if (tx_access !== 1'b0 || tx_packet !== '0 || rd_outstanding !== 8'd0 || rr_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got txa=%b txp=%h cnt=%0d uf=%b expected 0 0 0 0",
               tx_access, tx_packet, rd_outstanding, rr_underflow);
    end
    advance();
  endtask

  task automatic test_write_only();
    logic [PW-1:0] a5;
    a5 = '0; a5[7:0] = 8'hA5;
    wr_access = 1; wr_packet = a5; rd_access = 0; rr_access = 0; tx_wait = 0;
    for (int i = 0; i < 3; i++) begin
      predict(); @(negedge clk);
      checks++;
      if (wr_wait !== 1'b0) begin errors++;
        $display("FAIL wo_wr_wait cyc%0d: got %b expected 0", i, wr_wait); end
      checks++;
      if (tx_access !== (i > 0) || (i > 0 && tx_packet !== a5)) begin errors++;
        $display("FAIL wo_tx cyc%0d: got txa=%b txp=%h expected txa=%b txp=%h",
                 i, tx_access, tx_packet, (i > 0), a5); end
      checks++;
      if (rd_outstanding !== 8'd0) begin errors++;
        $display("FAIL wo_cnt: got %0d expected 0", rd_outstanding); end
      advance();
    end
    wr_access = 0; predict(); advance();
  endtask

  task automatic test_contention();
    pulse_reset();
    wr_access = 1; rd_access = 1; rr_access = 0; tx_wait = 0;
    wr_packet = rand_pkt(); rd_packet = rand_pkt();
    for (int i = 0; i < 6; i++) begin
      predict(); @(negedge clk);
      checks++;
      if (wr_wait !== (i % 2 == 1) || rd_wait !== (i % 2 == 0)) begin errors++;
        $display("FAIL cont_order cyc%0d: got wr_wait=%b rd_wait=%b expected %b %b",
                 i, wr_wait, rd_wait, (i % 2 == 1), (i % 2 == 0)); end
      checks++;
      if (wr_wait !== !p_wr_go || rd_wait !== !p_rd_go) begin errors++;
        $display("FAIL cont_model cyc%0d: got %b %b expected %b %b",
                 i, wr_wait, rd_wait, !p_wr_go, !p_rd_go); end
      checks++;
      if (rd_outstanding !== 8'(i / 2)) begin errors++;
        $display("FAIL cont_cnt cyc%0d: got %0d expected %0d", i, rd_outstanding, i / 2); end
      advance();
      new_pkts();
    end
    drain();
  endtask

  task automatic test_back_pressure();
    logic [PW-1:0] held;
    wr_access = 1; rd_access = 1; rr_access = 0; tx_wait = 0;
    predict(); advance(); new_pkts();
    held = m_pkt;
    tx_wait = 1;
    for (int i = 0; i < 3; i++) begin
      predict(); @(negedge clk);
      checks++;
      if (tx_access !== 1'b1 || tx_packet !== held) begin errors++;
        $display("FAIL bp_hold cyc%0d: got txa=%b txp=%h expected 1 %h", i, tx_access, tx_packet, held); end
      checks++;
      if (wr_wait !== 1'b1 || rd_wait !== 1'b1) begin errors++;
        $display("FAIL bp_waits cyc%0d: got %b %b expected 1 1", i, wr_wait, rd_wait); end
      advance();
    end
    tx_wait = 0;
    predict(); @(negedge clk);
    checks++;
    if (wr_wait !== !p_wr_go || rd_wait !== !p_rd_go || (wr_wait && rd_wait)) begin errors++;
      $display("FAIL bp_release: got %b %b expected %b %b", wr_wait, rd_wait, !p_wr_go, !p_rd_go); end
    advance(); new_pkts();
    predict(); @(negedge clk);
    checks++;
    if (tx_access !== 1'b1 || tx_packet !== m_pkt) begin errors++;
      $display("FAIL bp_next: got txa=%b txp=%h expected 1 %h", tx_access, tx_packet, m_pkt); end
    advance();
    drain();
  endtask

  task automatic test_credit_limit();
    pulse_reset();
    wr_access = 0; rd_access = 1; rr_access = 0; tx_wait = 0; rd_packet = rand_pkt();
    for (int i = 0; i <= MAX_RD; i++) begin
      predict(); @(negedge clk);
      checks++;
      if (rd_wait !== (i >= MAX_RD) || rd_outstanding !== 8'(i)) begin errors++;
        $display("FAIL credit cyc%0d: got rd_wait=%b cnt=%0d expected %b %0d",
                 i, rd_wait, rd_outstanding, (i >= MAX_RD), i); end
      advance(); new_pkts();
    end
    rr_access = 1;
    predict(); @(negedge clk);
    checks++;
    if (rd_wait !== 1'b1) begin errors++;
      $display("FAIL credit_rr_same: got rd_wait=%b expected 1", rd_wait); end
    advance(); rr_access = 0;
    predict(); @(negedge clk);
    checks++;
    if (rd_outstanding !== 8'(MAX_RD - 1) || rd_wait !== 1'b0) begin errors++;
      $display("FAIL credit_freed: got cnt=%0d rd_wait=%b expected %0d 0",
               rd_outstanding, rd_wait, MAX_RD - 1); end
    advance(); new_pkts();
    predict(); @(negedge clk);
    checks++;
    if (rd_outstanding !== 8'(MAX_RD) || rd_wait !== 1'b1) begin errors++;
      $display("FAIL credit_refill: got cnt=%0d rd_wait=%b expected %0d 1",
               rd_outstanding, rd_wait, MAX_RD); end
    advance();
  endtask

  task automatic test_rr_same_cycle();
    rd_access = 0; wr_access = 0; tx_wait = 0;
    for (int i = 0; i < 20 && m_cnt > 1; i++) begin rr_access = 1; predict(); advance(); end
    rd_access = 1; rr_access = 1; rd_packet = rand_pkt();
    predict(); @(negedge clk);
    checks++;
    if (rd_wait !== 1'b0 || rd_outstanding !== 8'd1) begin errors++;
      $display("FAIL same_cycle_pre: got rd_wait=%b cnt=%0d expected 0 1", rd_wait, rd_outstanding); end
    advance();
    rd_access = 0; rr_access = 0;
    predict(); @(negedge clk);
    checks++;
    if (rd_outstanding !== 8'd1) begin errors++;
      $display("FAIL same_cycle_cnt: got %0d expected 1", rd_outstanding); end
    advance();
    drain();
    rr_access = 1; predict(); advance(); rr_access = 0;
    for (int i = 0; i < 2; i++) begin
      predict(); @(negedge clk);
      checks++;
      if (rr_underflow !== 1'b1 || rd_outstanding !== 8'd0) begin errors++;
        $display("FAIL underflow cyc%0d: got uf=%b cnt=%0d expected 1 0", i, rr_underflow, rd_outstanding); end
      advance();
    end
    pulse_reset();
    predict(); @(negedge clk);
    checks++;
    if (rr_underflow !== 1'b0) begin errors++;
      $display("FAIL underflow_clear: got %b expected 0", rr_underflow); end
    advance();
  endtask

  task automatic test_reset_midstream();
    pulse_reset();
    wr_access = 1; rd_access = 1; rr_access = 0; tx_wait = 0;
    wr_packet = rand_pkt(); rd_packet = rand_pkt();
    for (int i = 0; i < 20 && m_cnt < MAX_RD; i++) begin predict(); advance(); new_pkts(); end
    checks++;
    if (rd_outstanding !== 8'(MAX_RD) || tx_access !== 1'b1) begin errors++;
      $display("FAIL mid_setup: got cnt=%0d txa=%b expected %0d 1", rd_outstanding, tx_access, MAX_RD); end
    tx_wait = 1; aresetn = 0;
    predict(); @(negedge clk);
    checks++;
    if (wr_wait !== 1'b1 || rd_wait !== 1'b1) begin errors++;
      $display("FAIL mid_waits: got %b %b expected 1 1", wr_wait, rd_wait); end
    advance();
    aresetn = 1; tx_wait = 0;
    predict(); @(negedge clk);
    checks++;
    if (tx_access !== 1'b0 || rd_outstanding !== 8'd0) begin errors++;
      $display("FAIL mid_state: got txa=%b cnt=%0d expected 0 0", tx_access, rd_outstanding); end
    checks++;
    if (wr_wait !== 1'b0 || rd_wait !== 1'b1) begin errors++;
      $display("FAIL mid_first_grant: got wr_wait=%b rd_wait=%b expected 0 1", wr_wait, rd_wait); end
    advance();
    drain();
  endtask

  task automatic test_random();
    pulse_reset();
    wr_access = 0; rd_access = 0; rr_access = 0; tx_wait = 0;
    p_wr_go = 0; p_rd_go = 0;
    for (int i = 0; i < 400; i++) begin
      refresh_sources(70);
      tx_wait   = ($urandom_range(2) == 0);
      rr_access = ($urandom_range(3) == 0) && (m_cnt > 0 || $urandom_range(19) == 0);
      predict(); @(negedge clk);
      checks++;
      if (wr_wait !== !p_wr_go || rd_wait !== !p_rd_go) begin errors++;
        $display("FAIL rnd_waits cyc%0d: got %b %b expected %b %b", i, wr_wait, rd_wait, !p_wr_go, !p_rd_go); end
      checks++;
      if (tx_access !== m_txv || (m_txv && tx_packet !== m_pkt)) begin errors++;
        $display("FAIL rnd_tx cyc%0d: got %b %h expected %b %h", i, tx_access, tx_packet, m_txv, m_pkt); end
      checks++;
      if (rd_outstanding !== 8'(m_cnt) || rr_underflow !== m_uf) begin errors++;
        $display("FAIL rnd_credit cyc%0d: got cnt=%0d uf=%b expected %0d %b",
                 i, rd_outstanding, rr_underflow, m_cnt, m_uf); end
      advance();
    end
    wr_access = 0; rd_access = 0; rr_access = 0; tx_wait = 0;
    predict(); advance();
    predict(); advance();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and report ----------------
  initial begin
    aresetn = 0; wr_access = 0; rd_access = 0; rr_access = 0; tx_wait = 0;
    wr_packet = '0; rd_packet = '0;
    m_txv = 0; m_pkt = '0; m_cnt = 0; m_uf = 0; m_last_wr = 0;
    p_load = 0; p_wr_go = 0; p_rd_go = 0;
    @(posedge clk); #1;
    test_reset();
    test_write_only();
    test_contention();
    test_back_pressure();
    test_credit_limit();
    test_rr_same_cycle();
    test_reset_midstream();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin errors++;
      $display("FAIL leftover: %0d expected packets never delivered", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
